btb_assoc_plru: RTL and testbench
=================================

// Module: btb_assoc_plru
// PURPOSE
//  Parametrised set-associative branch target buffer for the IF/EX pipeline.
//  - Same-cycle lookup of the fetch PC; updates come from the EX-stage branch resolution.
//  - Each way holds: valid bit, tag, target, saturating direction counter.
//  - Victim selection: first invalid way, then tree pseudo-LRU.
//  - A flush sequencer invalidates the whole table at runtime, one set per cycle.
// PARAMETERS
//  SETS      8   number of sets; power of two, >=2
//  WAYS      2   ways per set; power of two, 2..8
//  CTR_BITS  2   direction counter width; predict taken when MSB=1
//  PC_W      32  PC/target width; tag = PC[PC_W-1 : log2(SETS)+2], index = PC[log2(SETS)+1 : 2]
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst             in   1     asynchronous active-high reset
//  PC              in   PC_W  fetch PC to look up
//  valid           out  1     lookup hit (tag match on a valid way)
//  target          out  PC_W  target of hitting way; 0 on miss
//  predictedTaken  out  1     counter MSB of hitting way; 0 on miss
//  update          in   1     EX-stage resolved branch, sample this cycle
//  updatePC        in   PC_W  PC of resolved branch
//  updateTarget    in   PC_W  resolved target
//  updateTaken     in   1     resolved direction
//  flush           in   1     start full invalidation (pulse or level)
//  flush_busy      out  1     flush sequencer active
// BEHAVIOUR
//  Reset: asynchronous. Clears all valid bits, counters and PLRU bits, and forces FSM to IDLE.
//   Outputs while in reset: valid=0, target=0, predictedTaken=0, flush_busy=0.
//  Lookup: combinational, same cycle as PC.
//   - Tag matches on more than one valid way cannot occur by construction.
//   - A lookup sees pre-edge contents; no bypass from an update in the same cycle.
//  Lookup hit: at the clock edge, the set's PLRU is pointed away from the hit way.
//  Update with tag hit (written at the clock edge):
//   - Counter does +1 if taken, -1 if not taken, saturating at 0 and 2^CTR_BITS-1.
//   - Target is overwritten only when updateTaken=1.
//   - PLRU is touched for that way.
//  Update with tag miss and updateTaken=1, allocate:
//   - Way = lowest-numbered invalid way, else the PLRU victim.
//   - Write valid=1, tag, target, counter=2^(CTR_BITS-1) (weakly taken), and touch PLRU.
//  Update with tag miss and updateTaken=0: no state change.
//  Lookup and update in the same set, same cycle: the update's PLRU touch wins and the
//   lookup touch is dropped. Lookup and update in different sets: both touches apply.
//  PLRU: WAYS-1 bits per set, binary tree.
//   - A bit=0 means the victim is in the left (lower) half.
//   - Touch sets the bits on the path to point away from the touched way.
//  Flush FSM: IDLE -> FLUSH -> IDLE.
//   - IDLE: flush=1 at an edge -> FLUSH with set counter=0 and flush_busy=1 from the next cycle.
//   - FLUSH, each cycle: clear valid and PLRU of set[counter], then counter++.
//   - FLUSH, last set (SETS-1) cleared -> IDLE; flush_busy=0 the following cycle.
//     Flush therefore takes exactly SETS cycles.
//   - flush asserted while busy is ignored; the flush does not restart.
//   - While flush_busy=1: valid=0, predictedTaken=0, target=0, and updates are dropped entirely.
//   - Same-cycle flush and update while IDLE: the update is applied, then the flush starts next cycle.
//  Reset asserted mid-flush: immediate IDLE, table cleared, flush_busy=0.
//  Widths: counter arithmetic is in CTR_BITS with explicit saturation, with no wrap.
//   The index wraps naturally via the PC slice.
// TESTING
//  T1 SETS=8,WAYS=2:
//   - Stimulus: update PC=0x100,T=0x200,taken; then lookup PC=0x100.
//   - Required: valid=1, target=0x200, predictedTaken=1.
//   - Stimulus: two not-taken updates, then lookup.
//   - Required: valid=1, predictedTaken=0.
//  T2 counter saturation:
//   - Stimulus: 5 taken updates to 0x100.
//   - Required: counter=3.
//   - Stimulus: 5 not-taken updates.
//   - Required: counter=0 and entry still valid.
//  T3 PLRU replacement, WAYS=2, all PCs index 0:
//   - Stimulus: allocate 0x000 then 0x020; lookup 0x000; allocate 0x040.
//   - Required: 0x020 evicted; 0x000 and 0x040 hit.
//  T4 not-taken miss:
//   - Stimulus: update PC=0x300 not taken; lookup 0x300.
//   - Required: valid=0.
//  T5 flush, SETS=8:
//   - Stimulus: fill 8 sets, pulse flush.
//   - Required: flush_busy=1 for exactly 8 cycles; valid=0 throughout; an update during the flush is dropped; all lookups miss afterward.
//  T6 async reset:
//   - Stimulus: assert rst mid-cycle during flush cycle 3.
//   - Required: flush_busy=0 and valid=0 immediately; after release, a prior entry misses.

Source files
------------

// File: rtl/btb_assoc_plru.sv
// btb_assoc_plru: set-associative branch target buffer with tree pseudo-LRU replacement
// and a one-set-per-cycle flush sequencer.
module btb_assoc_plru #(
  parameter int SETS = 8,
  parameter int WAYS = 2,
  parameter int CTR_BITS = 2,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] PC,
  output logic            valid,
  output logic [PC_W-1:0] target,
  output logic            predictedTaken,
  input  logic            update,
  input  logic [PC_W-1:0] updatePC,
  input  logic [PC_W-1:0] updateTarget,
  input  logic            updateTaken,
  input  logic            flush,
  output logic            flush_busy
);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int TW = PC_W - IW - 2;
  localparam logic [CTR_BITS-1:0] CMAX = '1;
  localparam logic [CTR_BITS-1:0] CINIT = CTR_BITS'(1) << (CTR_BITS - 1);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  logic [WAYS-2:0] plru_q [SETS];
  logic [WAYS-2:0] plru_d [SETS];
  logic [TW-1:0] tag_q [SETS][WAYS];
  logic [TW-1:0] tag_d [SETS][WAYS];
  logic [PC_W-1:0] tgt_q [SETS][WAYS];
  logic [PC_W-1:0] tgt_d [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_d [SETS][WAYS];
  logic [IW-1:0] li, ui;
  logic [TW-1:0] lt, ut;
  logic lhit, uhit;
  logic [WW-1:0] lway, uway, free_way, aw;
  logic [CTR_BITS-1:0] uctr;
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{PC[1:0], updatePC[1:0]};
  assign li = PC[IW+1:2];
  assign lt = PC[PC_W-1:IW+2];
  assign ui = updatePC[IW+1:2];
  assign ut = updatePC[PC_W-1:IW+2];
  // Walk the tree: a 0 bit steers toward the lower half.
  function automatic logic [WW-1:0] victim(input logic [WAYS-2:0] p);
    int n;
    n = 1;
    for (int l = 0; l < WW; l++) n = 2 * n + int'(p[n-1]);
    return WW'(n - WAYS);
  endfunction
  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] p, input logic [WW-1:0] w);
    logic [WAYS-2:0] r;
    int n;
    r = p;
    n = 1;
    for (int l = 0; l < WW; l++) begin
      r[n-1] = ~w[WW-1-l];
      n = 2 * n + int'(w[WW-1-l]);
    end
    return r;
  endfunction
  always_comb begin
    lhit = 1'b0;
    lway = '0;
    uhit = 1'b0;
    uway = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[li][w] && tag_q[li][w] == lt) begin
        lhit = 1'b1;
        lway = WW'(w);
      end
      if (valid_q[ui][w] && tag_q[ui][w] == ut) begin
        uhit = 1'b1;
        uway = WW'(w);
      end
      if (!valid_q[ui][w]) free_way = WW'(w);
    end
  end
  assign flush_busy = state_q == FLUSH;
  assign valid = lhit && !flush_busy;
  assign target = valid ? tgt_q[li][lway] : '0;
  assign predictedTaken = valid && ctr_q[li][lway][CTR_BITS-1];
  assign aw = &valid_q[ui] ? victim(plru_q[ui]) : free_way;
  assign uctr = ctr_q[ui][uway];
  // The update touch is computed from the registered PLRU, so in a shared set it overrides the lookup touch.
  always_comb begin
    valid_d = valid_q;
    plru_d = plru_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    state_d = state_q;
    cnt_d = cnt_q;
    if (valid) plru_d[li] = touch(plru_q[li], lway);
    if (update && !flush_busy) begin
      if (uhit) begin
        ctr_d[ui][uway] = updateTaken ? (uctr == CMAX ? uctr : uctr + CTR_BITS'(1))
                                      : (uctr == '0 ? uctr : uctr - CTR_BITS'(1));
        if (updateTaken) tgt_d[ui][uway] = updateTarget;
        plru_d[ui] = touch(plru_q[ui], uway);
      end else if (updateTaken) begin
        valid_d[ui][aw] = 1'b1;
        tag_d[ui][aw] = ut;
        tgt_d[ui][aw] = updateTarget;
        ctr_d[ui][aw] = CINIT;
        plru_d[ui] = touch(plru_q[ui], aw);
      end
    end
    if (flush_busy) begin
      valid_d[cnt_q] = '0;
      plru_d[cnt_q] = '0;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == IW'(SETS - 1) ? IDLE : FLUSH;
    end else if (flush) begin
      state_d = FLUSH;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          tgt_q[s][w] <= '0;
          ctr_q[s][w] <= '0;
        end
      end
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      plru_q <= plru_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_btb_assoc_plru.sv
// tb_btb_assoc_plru: directed scenarios for btb_assoc_plru with hand-computed expectations.
module tb_btb_assoc_plru;
  localparam logic [31:0] IDLE_PC = 32'hFFC;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] PC = IDLE_PC;
  logic [31:0] updatePC = '0;
  logic [31:0] updateTarget = '0;
  logic update = 1'b0;
  logic updateTaken = 1'b0;
  logic flush = 1'b0;
  logic valid, predictedTaken, flush_busy;
  logic [31:0] target;
  int checks = 0;
  int errors = 0;
  btb_assoc_plru dut (
    .clk(clk), .rst(rst), .PC(PC), .valid(valid), .target(target),
    .predictedTaken(predictedTaken), .update(update), .updatePC(updatePC),
    .updateTarget(updateTarget), .updateTaken(updateTaken), .flush(flush),
    .flush_busy(flush_busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input logic tk);
    PC = IDLE_PC;
    update = 1'b1;
    updatePC = pc;
    updateTarget = tg;
    updateTaken = tk;
    tick();
    update = 1'b0;
  endtask
  task automatic look(input logic [31:0] pc);
    PC = pc;
    @(negedge clk);
  endtask
  task automatic rst_pulse;
    PC = IDLE_PC;
    tick();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    PC = 32'h100;
    #2;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    checks++; if (target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h expected 0", target); end
    checks++; if (predictedTaken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b expected 0", predictedTaken); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", flush_busy); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_basic;
    upd(32'h100, 32'h200, 1'b1);
    look(32'h100);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %0b expected 1", valid); end
    checks++; if (target !== 32'h200) begin errors++; $display("FAIL t1_target: got %h expected 200", target); end
    checks++; if (predictedTaken !== 1'b1) begin errors++; $display("FAIL t1_pred: got %0b expected 1", predictedTaken); end
    upd(32'h100, 32'hDEAD, 1'b0);
    upd(32'h100, 32'hDEAD, 1'b0);
    look(32'h100);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t1_nt_valid: got %0b expected 1", valid); end
    checks++; if (predictedTaken !== 1'b0) begin errors++; $display("FAIL t1_nt_pred: got %0b expected 0", predictedTaken); end
    checks++; if (target !== 32'h200) begin errors++; $display("FAIL t1_nt_target: got %h expected 200", target); end
  endtask
  task automatic test_saturation;
    repeat (5) upd(32'h100, 32'h200, 1'b1);
    look(32'h100);
    checks++; if (predictedTaken !== 1'b1) begin errors++; $display("FAIL t2_sat_hi: got %0b expected 1", predictedTaken); end
    upd(32'h100, 32'h200, 1'b0);
    look(32'h100);
    checks++; if (predictedTaken !== 1'b1) begin errors++; $display("FAIL t2_ctr3_minus1: got %0b expected 1", predictedTaken); end
    upd(32'h100, 32'h200, 1'b0);
    look(32'h100);
    checks++; if (predictedTaken !== 1'b0) begin errors++; $display("FAIL t2_ctr3_minus2: got %0b expected 0", predictedTaken); end
    repeat (3) upd(32'h100, 32'h200, 1'b0);
    look(32'h100);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t2_sat_lo_valid: got %0b expected 1", valid); end
    checks++; if (predictedTaken !== 1'b0) begin errors++; $display("FAIL t2_sat_lo_pred: got %0b expected 0", predictedTaken); end
    upd(32'h100, 32'h200, 1'b1);
    look(32'h100);
    checks++; if (predictedTaken !== 1'b0) begin errors++; $display("FAIL t2_ctr0_plus1: got %0b expected 0", predictedTaken); end
    upd(32'h100, 32'h200, 1'b1);
    look(32'h100);
    checks++; if (predictedTaken !== 1'b1) begin errors++; $display("FAIL t2_ctr0_plus2: got %0b expected 1", predictedTaken); end
  endtask
  task automatic test_plru;
    rst_pulse();
    upd(32'h000, 32'h10, 1'b1);
    upd(32'h020, 32'h20, 1'b1);
    look(32'h000);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t3_pre_hit: got %0b expected 1", valid); end
    tick();
    upd(32'h040, 32'h40, 1'b1);
    look(32'h020);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t3_evicted: got %0b expected 0", valid); end
    look(32'h000);
    checks++; if (valid !== 1'b1 || target !== 32'h10) begin errors++; $display("FAIL t3_keep: got %0b/%h expected 1/10", valid, target); end
    look(32'h040);
    checks++; if (valid !== 1'b1 || target !== 32'h40) begin errors++; $display("FAIL t3_new: got %0b/%h expected 1/40", valid, target); end
  endtask
  task automatic test_not_taken_miss;
    upd(32'h300, 32'h400, 1'b0);
    look(32'h300);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t4_valid: got %0b expected 0", valid); end
    checks++; if (target !== 32'h0) begin errors++; $display("FAIL t4_target: got %h expected 0", target); end
  endtask
  task automatic test_flush;
    int n;
    for (int i = 0; i < 8; i++) upd(32'h1000 + 32'(4 * i), 32'h5000 + 32'(i), 1'b1);
    look(32'h101C);
    checks++; if (valid !== 1'b1 || target !== 32'h5007) begin errors++; $display("FAIL t5_fill: got %0b/%h expected 1/5007", valid, target); end
    PC = 32'h1000;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (flush_busy === 1'b1 && n < 20) begin
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t5_busy_valid: cycle %0d got %0b expected 0", n, valid); end
      if (n == 3) begin
        update = 1'b1;
        updatePC = 32'h2004;
        updateTarget = 32'h6000;
        updateTaken = 1'b1;
      end
      if (n == 4) begin
        update = 1'b0;
        flush = 1'b1;
      end
      if (n == 5) flush = 1'b0;
      tick();
      n++;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL t5_busy_cycles: got %0d expected 8", n); end
    for (int i = 0; i < 8; i++) begin
      look(32'h1000 + 32'(4 * i));
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t5_after_set%0d: got %0b expected 0", i, valid); end
    end
    look(32'h2004);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t5_dropped_update: got %0b expected 0", valid); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL t5_idle: got %0b expected 0", flush_busy); end
  endtask
  task automatic test_async_reset;
    upd(32'h1014, 32'h7000, 1'b1);
    look(32'h1014);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t6_pre_hit: got %0b expected 1", valid); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL t6_busy_before: got %0b expected 1", flush_busy); end
    #3 rst = 1'b1;
    #1;
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL t6_busy_in_rst: got %0b expected 0", flush_busy); end
    checks++; if (valid !== 1'b0 || target !== 32'h0) begin errors++; $display("FAIL t6_out_in_rst: got %0b/%h expected 0/0", valid, target); end
    #2 rst = 1'b0;
    look(32'h1014);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t6_cleared: got %0b expected 0", valid); end
    tick();
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL t6_idle_after: got %0b expected 0", flush_busy); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_plru();
    test_not_taken_miss();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
